// File: rtl/seg_frame_decoder.sv
// seg_frame_decoder
//   Turns a stream of 8-bit seven-segment patterns (one per digit, HEX0 first) back into
//   hex nibbles. NUM_DIGITS patterns form one frame. Each digit is flagged as blank or
//   undecodable, and the frame is handed on with a valid/ready handshake.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   RESET      in   synchronous active-high reset
//   IN_SEG     in   segment pattern, [7:1] = a..g, [0] = dp, 1 = lit
//   IN_FIRST   in   beat is digit 0 of a frame
//   IN_VALID   in   IN_SEG / IN_FIRST valid
//   IN_READY   out  block can accept a beat
//   OUT_VALUE  out  decoded nibbles, digit i at [4i+3:4i]
//   OUT_DP     out  decimal point per digit
//   OUT_BLANK  out  digit had no lit segments
//   OUT_ERR    out  digit pattern not decodable and not blank
//   OUT_VALID  out  frame available
//   OUT_READY  in   consumer takes frame
//   RESYNC     out  one-cycle pulse when a partial frame was discarded
module seg_frame_decoder #(
    parameter int unsigned NUM_DIGITS = 6
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET,
    input  logic [7:0]              IN_SEG,
    input  logic                    IN_FIRST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    output logic [4*NUM_DIGITS-1:0] OUT_VALUE,
    output logic [NUM_DIGITS-1:0]   OUT_DP,
    output logic [NUM_DIGITS-1:0]   OUT_BLANK,
    output logic [NUM_DIGITS-1:0]   OUT_ERR,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic                    RESYNC
);

    localparam logic [2:0] LastIdx = 3'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {StCollect, StHold} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              index_q, index_d;
    logic                    in_ready_q, in_ready_d;
    logic                    resync_q, resync_d;

    // Per-frame working slots; the last beat is merged combinationally so the
    // output registers can be loaded on the same edge that enters HOLD.
    logic [4*NUM_DIGITS-1:0] slot_val_q, slot_val_d;
    logic [NUM_DIGITS-1:0]   slot_dp_q, slot_dp_d;
    logic [NUM_DIGITS-1:0]   slot_blank_q, slot_blank_d;
    logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;

    logic [4*NUM_DIGITS-1:0] out_val_q;
    logic [NUM_DIGITS-1:0]   out_dp_q, out_blank_q, out_err_q;

    logic [3:0]              seg_nib;
    logic                    seg_blank, seg_err;
    logic                    store, last;
    logic [2:0]              slot;

    // Pattern decode, dp bit masked off.
    always_comb begin
        seg_nib   = 4'h0;
        seg_blank = 1'b0;
        seg_err   = 1'b0;
        case ({IN_SEG[7:1], 1'b0})
            8'hFC:   seg_nib = 4'h0;
            8'h60:   seg_nib = 4'h1;
            8'hDA:   seg_nib = 4'h2;
            8'hF2:   seg_nib = 4'h3;
            8'h66:   seg_nib = 4'h4;
            8'hB6:   seg_nib = 4'h5;
            8'hBE:   seg_nib = 4'h6;
            8'hE0:   seg_nib = 4'h7;
            8'hFE:   seg_nib = 4'h8;
            8'hF6:   seg_nib = 4'h9;
            8'hEE:   seg_nib = 4'hA;
            8'h3E:   seg_nib = 4'hB;
            8'h9C:   seg_nib = 4'hC;
            8'h7A:   seg_nib = 4'hD;
            8'h9E:   seg_nib = 4'hE;
            8'h8E:   seg_nib = 4'hF;
            8'h00:   seg_blank = 1'b1;
            default: seg_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        resync_d     = 1'b0;
        store        = 1'b0;
        last         = 1'b0;
        slot         = 3'd0;
        slot_val_d   = slot_val_q;
        slot_dp_d    = slot_dp_q;
        slot_blank_d = slot_blank_q;
        slot_err_d   = slot_err_q;

        unique case (state_q)
            StCollect: begin
                if (IN_VALID && in_ready_q) begin
                    if (IN_FIRST) begin
                        // A first-beat always restarts the frame at digit 0.
                        store    = 1'b1;
                        slot     = 3'd0;
                        resync_d = (index_q != 3'd0);
                    end else if (index_q != 3'd0) begin
                        store = 1'b1;
                        slot  = index_q;
                    end
                    // index 0 without IN_FIRST: dropped to regain alignment
                end
            end
            StHold: begin
                if (OUT_READY) state_d = StCollect;
            end
            default: state_d = StCollect;
        endcase

        if (store) begin
            last                         = (slot == LastIdx);
            index_d                      = last ? 3'd0 : slot + 3'd1;
            slot_val_d[4*slot +: 4]      = seg_nib;
            slot_dp_d[slot]              = IN_SEG[0];
            slot_blank_d[slot]           = seg_blank;
            slot_err_d[slot]             = seg_err;
            if (last) state_d = StHold;
        end

        in_ready_d = (state_d == StCollect);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q      <= StCollect;
            index_q      <= 3'd0;
            in_ready_q   <= 1'b0;
            resync_q     <= 1'b0;
            slot_val_q   <= '0;
            slot_dp_q    <= '0;
            slot_blank_q <= '0;
            slot_err_q   <= '0;
            out_val_q    <= '0;
            out_dp_q     <= '0;
            out_blank_q  <= '0;
            out_err_q    <= '0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            in_ready_q   <= in_ready_d;
            resync_q     <= resync_d;
            slot_val_q   <= slot_val_d;
            slot_dp_q    <= slot_dp_d;
            slot_blank_q <= slot_blank_d;
            slot_err_q   <= slot_err_d;
            if (state_q == StCollect && state_d == StHold) begin
                out_val_q   <= slot_val_d;
                out_dp_q    <= slot_dp_d;
                out_blank_q <= slot_blank_d;
                out_err_q   <= slot_err_d;
            end
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = (state_q == StHold);
    assign RESYNC    = resync_q;
    assign OUT_VALUE = out_val_q;
    assign OUT_DP    = out_dp_q;
    assign OUT_BLANK = out_blank_q;
    assign OUT_ERR   = out_err_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// tb_seg_frame_decoder
//   Directed-vector bench for seg_frame_decoder (NUM_DIGITS = 6). Inputs are driven 1 ns
//   after the rising edge and outputs are sampled there as well.
module tb_seg_frame_decoder;

    logic        CLOCK_50 = 1'b0;
    logic        RESET;
    logic [7:0]  IN_SEG;
    logic        IN_FIRST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [23:0] OUT_VALUE;
    logic [5:0]  OUT_DP;
    logic [5:0]  OUT_BLANK;
    logic [5:0]  OUT_ERR;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        RESYNC;

    int n_tests = 0;
    int n_fail  = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    seg_frame_decoder #(.NUM_DIGITS(6)) dut (
        .CLOCK_50  (CLOCK_50),
        .RESET     (RESET),
        .IN_SEG    (IN_SEG),
        .IN_FIRST  (IN_FIRST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_VALUE (OUT_VALUE),
        .OUT_DP    (OUT_DP),
        .OUT_BLANK (OUT_BLANK),
        .OUT_ERR   (OUT_ERR),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .RESYNC    (RESYNC)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Presents one beat and returns 1 ns after the edge that accepts it.
    task automatic send(input logic [7:0] seg, input logic first);
        IN_SEG   = seg;
        IN_FIRST = first;
        IN_VALID = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (IN_READY) begin
                tick();
                return;
            end
            tick();
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    // segs[8i+7:8i] is digit i; IN_FIRST on digit 0 only.
    task automatic send_frame(input logic [47:0] segs);
        for (int i = 0; i < 6; i++) send(segs[8*i +: 8], (i == 0));
        IN_VALID = 1'b0;
        IN_FIRST = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [23:0] val, input logic [5:0] dp,
                             input logic [5:0] blank, input logic [5:0] err);
        check({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd1);
        check({tag, "_value"}, {8'd0, OUT_VALUE}, {8'd0, val});
        check({tag, "_dp"},    {26'd0, OUT_DP}, {26'd0, dp});
        check({tag, "_blank"}, {26'd0, OUT_BLANK}, {26'd0, blank});
        check({tag, "_err"},   {26'd0, OUT_ERR}, {26'd0, err});
    endtask

    // With OUT_READY high: frame leaves after one cycle, outputs stay put.
    task automatic consume(input string tag, input logic [23:0] val);
        tick();
        check({tag, "_valid_drop"}, {31'd0, OUT_VALID}, 32'd0);
        check({tag, "_value_kept"}, {8'd0, OUT_VALUE}, {8'd0, val});
    endtask

    initial begin
        RESET     = 1'b1;
        IN_SEG    = 8'h00;
        IN_FIRST  = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        tick();
        tick();
        check("rst_in_ready",  {31'd0, IN_READY}, 32'd0);
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_resync",    {31'd0, RESYNC}, 32'd0);
        check("rst_value",     {8'd0, OUT_VALUE}, 32'd0);
        check("rst_flags",     {14'd0, OUT_DP, OUT_BLANK, OUT_ERR}, 32'd0);
        RESET = 1'b0;
        tick();
        check("post_rst_in_ready", {31'd0, IN_READY}, 32'd1);

        // 1: plain digits 0..5
        send_frame({8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC});
        check_out("t1", 24'h543210, 6'b000000, 6'b000000, 6'b000000);
        consume("t1", 24'h543210);

        // 2: dp bits and a blank digit
        send_frame({8'h8E, 8'h9E, 8'h00, 8'hFD, 8'hFC, 8'hE1});
        check_out("t2", 24'hFE0007, 6'b000101, 6'b001000, 6'b000000);
        consume("t2", 24'hFE0007);

        // 3: undecodable digit 1 (only segment g lit)
        send_frame({8'h60, 8'h60, 8'h60, 8'h60, 8'h02, 8'hFC});
        check_out("t3", 24'h111100, 6'b000000, 6'b000000, 6'b000010);
        consume("t3", 24'h111100);

        // 4: partial frame then a new first beat
        send(8'hFC, 1'b1);
        send(8'h60, 1'b0);
        send(8'hDA, 1'b0);
        check("t4_no_resync", {31'd0, RESYNC}, 32'd0);
        send(8'h66, 1'b1);
        check("t4_resync", {31'd0, RESYNC}, 32'd1);
        send(8'hB6, 1'b0);
        check("t4_resync_once", {31'd0, RESYNC}, 32'd0);
        send(8'hBE, 1'b0);
        send(8'hE0, 1'b0);
        send(8'hFE, 1'b0);
        send(8'hFF, 1'b0);
        IN_VALID = 1'b0;
        check_out("t4", 24'h887654, 6'b100000, 6'b000000, 6'b000000);
        consume("t4", 24'h887654);

        // 5: back-pressure while input keeps offering a beat
        OUT_READY = 1'b0;
        send_frame({8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6});
        IN_SEG   = 8'hFC;
        IN_FIRST = 1'b1;
        IN_VALID = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("t5_in_ready", {31'd0, IN_READY}, 32'd0);
            check("t5_frozen", {7'd0, OUT_VALID, OUT_VALUE}, {7'd0, 1'b1, 24'hEDCBA9});
            tick();
        end
        OUT_READY = 1'b1;
        send_frame({8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC});
        check_out("t5", 24'h543210, 6'b000000, 6'b000000, 6'b000000);
        consume("t5", 24'h543210);

        // 6: unaligned beats dropped, then a full frame
        send(8'h60, 1'b0);
        send(8'hDA, 1'b0);
        check("t6_drop_no_valid", {31'd0, OUT_VALID}, 32'd0);
        send_frame({8'hBE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A});
        check_out("t6", 24'h69ABCD, 6'b000000, 6'b000000, 6'b000000);
        consume("t6", 24'h69ABCD);

        // reset mid-frame
        send(8'hFC, 1'b1);
        send(8'h60, 1'b0);
        send(8'hDA, 1'b0);
        IN_VALID = 1'b0;
        RESET    = 1'b1;
        tick();
        check("t6_rst_valid", {31'd0, OUT_VALID}, 32'd0);
        check("t6_rst_ready", {31'd0, IN_READY}, 32'd0);
        check("t6_rst_value", {8'd0, OUT_VALUE}, 32'd0);
        RESET = 1'b0;
        tick();
        check("t6_post_rst_valid", {31'd0, OUT_VALID}, 32'd0);
        send_frame({8'hFC, 8'h66, 8'hB6, 8'hE0, 8'h9E, 8'h8E});
        check_out("t6r", 24'h0457EF, 6'b000000, 6'b000000, 6'b000000);
        consume("t6r", 24'h0457EF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
